// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one shift-add unsigned multiplier between NREQ requesters.
// Optional MULT_EARLY_EXIT_EN: RUN ends as soon as the remaining multiplier bits are all zero.
module mult_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   arg1_bus,
  input  logic [NREQ*WIDTH-1:0]   arg2_bus,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [2*WIDTH-1:0]      product,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [OW-1:0]      ptr_q, ptr_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   arg1Arr [NREQ];
  logic [WIDTH-1:0]   arg2Arr [NREQ];
  logic [OW-1:0]      win;
  logic               found;
  int                 scanIdx;
  logic [2*WIDTH-1:0] sum;
  logic               lastEdge;

  for (genvar g = 0; g < NREQ; g++) begin : gUnpack
    assign arg1Arr[g] = arg1_bus[g*WIDTH +: WIDTH];
    assign arg2Arr[g] = arg2_bus[g*WIDTH +: WIDTH];
  end

  // Scan upward from the pointer, wrapping at NREQ (not at a power of two).
  always_comb begin
    win     = '0;
    found   = 1'b0;
    scanIdx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scanIdx = int'(ptr_q) + k;
      if (scanIdx >= NREQ) scanIdx = scanIdx - NREQ;
      if (!found && req[OW'(scanIdx)]) begin
        found = 1'b1;
        win   = OW'(scanIdx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    done_d    = done_q;
    product_d = product_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    sum       = '0;
    lastEdge  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
          owner_d = win;
          mcand_d = {{WIDTH{1'b0}}, arg1Arr[win]};
          mplr_d  = arg2Arr[win];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum     = acc_q + (mplr_q[0] ? mcand_q : '0);
        acc_d   = sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
`ifdef MULT_EARLY_EXIT_EN
        lastEdge = (cnt_q == CW'(WIDTH - 1)) || ((mplr_q >> 1) == '0);
`else
        lastEdge = (cnt_q == CW'(WIDTH - 1));
`endif
        if (lastEdge) begin
          product_d = sum;
          done_d    = gnt_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        done_d  = '0;
        gnt_d   = '0;
        ptr_d   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      product_q <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      product_q <= product_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign product = product_q;
  assign owner   = owner_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter; expected latency follows MULT_EARLY_EXIT_EN when defined.
module tb_mult_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic                    clk = 1'b0;
  logic                    res;
  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   arg1_bus;
  logic [NREQ*WIDTH-1:0]   arg2_bus;
  logic [NREQ-1:0]         gnt;
  logic [NREQ-1:0]         done;
  logic [2*WIDTH-1:0]      product;
  logic [$clog2(NREQ)-1:0] owner;
  logic                    busy;

  typedef struct {
    int          idx;
    logic [31:0] prod;
    int          lat;
  } exp_t;

  exp_t expQ[$];
  exp_t expCur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lastGrant = 0;
  int   lastLat = 0;
  bit   havePrev = 0;
  bit   spacingOn = 0;
  logic [NREQ-1:0] prevGnt = '0;

  mult_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .res(res), .req(req), .arg1_bus(arg1_bus), .arg2_bus(arg2_bus),
    .gnt(gnt), .done(done), .product(product), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int runEdges(input logic [WIDTH-1:0] a2);
    int n;
    n = WIDTH;
`ifdef MULT_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < WIDTH; i++) if (a2[i]) n = i + 1;
`endif
    return n;
  endfunction

  // Scoreboard: every completion pops the oldest expectation and checks timing from its grant.
  always @(negedge clk) begin
    cyc++;
    if (res) begin
      prevGnt  = '0;
      havePrev = 0;
    end else begin
      if (gnt != '0 && prevGnt == '0) begin
        if (spacingOn && havePrev) checkOutput("grant_spacing", cyc - lastGrant, lastLat + 2);
        lastGrant = cyc;
        havePrev  = 1;
      end
      if (done != '0) begin
        if (expQ.size() == 0) checkOutput("unexpected_done", done, 0);
        else begin
          expCur = expQ.pop_front();
          checkOutput("done_onehot", done, 64'(1) << expCur.idx);
          checkOutput("product", product, expCur.prod);
          checkOutput("owner", owner, expCur.idx);
          checkOutput("done_latency", cyc - lastGrant, expCur.lat);
          lastLat = expCur.lat;
        end
      end
      prevGnt = gnt;
    end
  end

  task automatic applyStimulus(input int idx, input logic [WIDTH-1:0] a1,
                               input logic [WIDTH-1:0] a2, input bit push);
    arg1_bus[idx*WIDTH +: WIDTH] = a1;
    arg2_bus[idx*WIDTH +: WIDTH] = a2;
    req[idx] = 1'b1;
    if (push) expQ.push_back('{idx, 32'(a1) * 32'(a2), runEdges(a2)});
  endtask

  task automatic doReset();
    res = 1'b1;
    req = '0;
    arg1_bus = '0;
    arg2_bus = '0;
    expQ.delete();
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_product", product, 0);
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_busy", busy, 0);
    res = 1'b0;
  endtask

  task automatic waitGnt(input logic [NREQ-1:0] val);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt == val) begin ok = 1; break; end
    end
    checkOutput("grant_seen", ok, 1);
  endtask

  task automatic waitIdle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !busy) begin ok = 1; break; end
    end
    checkOutput("idle_reached", ok, 1);
  endtask

  task automatic runOne(input int idx, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] a2);
    applyStimulus(idx, a1, a2, 1);
    waitGnt(NREQ'(1) << idx);
    req[idx] = 1'b0;
    waitIdle();
  endtask

  initial begin
    int busyCnt;
    res = 1'b1;
    req = '0;
    arg1_bus = '0;
    arg2_bus = '0;

    // Single request: grant, busy window and product 15.
    doReset();
    @(negedge clk);
    applyStimulus(0, 16'd3, 16'd5, 1);
    @(negedge clk);
    checkOutput("t1_gnt", gnt, 4'b0001);
    req = '0;
    busyCnt = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      else break;
    end
    checkOutput("t1_busy_cycles", busyCnt, runEdges(16'd5) + 1);
    checkOutput("t1_gnt_after", gnt, 0);

    // All four held: rotation 0,1,2,3,0 with fixed grant spacing.
    doReset();
    spacingOn = 1;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, WIDTH'(i + 1), 16'd100, 1);
    applyStimulus(0, 16'd1, 16'd100, 1);
    for (int i = 0; i < 300 && expQ.size() > 1; i++) @(negedge clk);
    checkOutput("t2_four_done", expQ.size(), 1);
    waitGnt(4'b0001);
    req = '0;
    waitIdle();
    spacingOn = 0;

    // Max operands and a zero multiplier.
    doReset();
    runOne(0, 16'hFFFF, 16'hFFFF);
    runOne(1, 16'h1234, 16'h0000);

    // Operand change and req drop during RUN are ignored; req0 waits for DONE.
    doReset();
    applyStimulus(2, 16'd7, 16'h9009, 1);
    waitGnt(4'b0100);
    req[2] = 1'b0;
    repeat (4) @(negedge clk);
    arg1_bus[2*WIDTH +: WIDTH] = 16'd1000;
    arg2_bus[2*WIDTH +: WIDTH] = 16'd3;
    applyStimulus(0, 16'd11, 16'd13, 1);
    repeat (4) @(negedge clk);
    checkOutput("t4_gnt_hold", gnt, 4'b0100);
    waitGnt(4'b0001);
    req[0] = 1'b0;
    waitIdle();

    // Reset at RUN edge 8 aborts; pointer returns to 0 so req1 beats req3.
    doReset();
    runOne(2, 16'd5, 16'd6);
    applyStimulus(3, 16'h1234, 16'hFFFF, 0);
    waitGnt(4'b1000);
    req[3] = 1'b0;
    repeat (7) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    checkOutput("t5_gnt", gnt, 0);
    checkOutput("t5_done", done, 0);
    checkOutput("t5_product", product, 0);
    checkOutput("t5_busy", busy, 0);
    res = 1'b0;
    applyStimulus(1, 16'd25, 16'd40, 1);
    applyStimulus(3, 16'd3, 16'h0011, 1);
    waitGnt(4'b0010);
    checkOutput("t5_product_hold", product, 0);
    req[1] = 1'b0;
    waitGnt(4'b1000);
    req[3] = 1'b0;
    waitIdle();

    // Operand-dependent run lengths (early exit when enabled).
    doReset();
    runOne(0, 16'h0ABC, 16'd5);
    runOne(1, 16'h0777, 16'h0000);
    runOne(2, 16'h0003, 16'h8000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
